// File: rtl/rv_isa_pkg.sv
// RV64 encoding constants shared by the instruction encoder and the IMEM loader.
package rv_isa_pkg;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_SD  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;
   localparam logic [6:0] OPC_OPI = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_DWORD   = 3'b011;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_SLLI    = 3'b001;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_LD   = 4'd4,
      OP_SD   = 4'd5,
      OP_BEQ  = 4'd6,
      OP_ADDI = 4'd7,
      OP_SLLI = 4'd8
   } req_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_DONE
   } load_state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake from the program source plus the IMEM write port driven by the loader.
interface instr_encoder_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [12:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/rv_instr_encode.sv
// Combinational encoder: symbolic request -> 32-bit RV64 word plus an illegal flag
// (unknown op or immediate that does not fit the target format).
module rv_instr_encode
   import rv_isa_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic imm_fits12;

   assign imm_fits12 = (imm[12] == imm[11]);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD:  word = {F7_ZERO, rs2, rs1, F3_ADD_SUB, rd, OPC_R};
         OP_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_R};
         OP_AND:  word = {F7_ZERO, rs2, rs1, F3_AND,     rd, OPC_R};
         OP_OR:   word = {F7_ZERO, rs2, rs1, F3_OR,      rd, OPC_R};
         OP_LD: begin
            word    = {imm[11:0], rs1, F3_DWORD, rd, OPC_LD};
            illegal = !imm_fits12;
         end
         OP_SD: begin
            word    = {imm[11:5], rs2, rs1, F3_DWORD, imm[4:0], OPC_SD};
            illegal = !imm_fits12;
         end
         OP_BEQ: begin
            // B-type scatters the byte offset; bit 0 is implicit and must be clear
            word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BEQ};
            illegal = imm[0];
         end
         OP_ADDI: begin
            word    = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPI};
            illegal = !imm_fits12;
         end
         OP_SLLI: begin
            word    = {6'b000000, imm[5:0], rs1, F3_SLLI, rd, OPC_OPI};
            illegal = |imm[12:6];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests and writes them to IMEM at sequential word
// addresses, then appends a NOP tail on finish so the pipeline drains cleanly.
module instr_encoder_loader
   import rv_isa_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 64,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FLUSH_NOPS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        finish,
   instr_encoder_loader_if.slave       bus,
   output logic [$clog2(IMEM_DEPTH):0] count,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int unsigned IDX_W      = $clog2(IMEM_DEPTH);
   localparam int unsigned CNT_W      = IDX_W + 1;
   localparam int unsigned FILL_LIMIT = IMEM_DEPTH - FLUSH_NOPS;
   localparam int unsigned FC_W       = (FLUSH_NOPS > 1) ? $clog2(FLUSH_NOPS) : 1;

   load_state_e       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d, count_inc;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d, word_addr;
   logic [31:0]       wdata_q, wdata_d;
   logic              full, req_ready;
   logic [31:0]       enc_word;
   logic              enc_illegal;

   rv_instr_encode u_encode (
      .op      (bus.req_op),
      .rd      (bus.req_rd),
      .rs1     (bus.req_rs1),
      .rs2     (bus.req_rs2),
      .imm     (bus.req_imm),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // The last FLUSH_NOPS words are reserved for the tail, so the pointer can never wrap.
   assign full      = (count_q >= CNT_W'(FILL_LIMIT));
   assign req_ready = (state_q == ST_LOAD) && !full && !err_q && !start && !finish;
   assign word_addr = ADDR_W'({count_q[IDX_W-1:0], 2'b00});
   assign count_inc = (count_q == CNT_W'(IMEM_DEPTH)) ? count_q : count_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      flush_cnt_d = flush_cnt_q;
      err_d       = err_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if (start) begin
         state_d     = ST_LOAD;
         count_d     = '0;
         flush_cnt_d = '0;
         err_d       = 1'b0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (finish) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = '0;
               end else if (bus.req_valid && req_ready) begin
                  if (enc_illegal) begin
                     err_d = 1'b1;
                  end else begin
                     we_d    = 1'b1;
                     addr_d  = word_addr;
                     wdata_d = enc_word;
                     count_d = count_inc;
                  end
               end
            end
            ST_FLUSH: begin
               we_d        = 1'b1;
               addr_d      = word_addr;
               wdata_d     = NOP_WORD;
               count_d     = count_inc;
               flush_cnt_d = flush_cnt_q + FC_W'(1);
               if (flush_cnt_q == FC_W'(FLUSH_NOPS - 1)) begin
                  state_d = ST_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         flush_cnt_q <= '0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         flush_cnt_q <= flush_cnt_d;
         err_q       <= err_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign count          = count_q;
   assign busy           = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
   assign done           = (state_q == ST_DONE);
   assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an abstract per-cycle model checked every
// cycle, plus literal expectations taken from hand-assembled RV64 words.
module tb_instr_encoder_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 8;
   localparam int NOPS  = 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic       finish = 1'b0;
   logic [6:0] count;
   logic       busy, done, err;

   int checks = 0;
   int errors = 0;

   instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

   instr_encoder_loader #(
      .IMEM_DEPTH (DEPTH),
      .ADDR_W     (AW),
      .FLUSH_NOPS (NOPS)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .finish (finish),
      .bus    (bus),
      .count  (count),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- abstract model ----------------
   // mode: 0 idle, 1 load, 2 flush, 3 done
   int          m_mode, m_count, m_flush_left;
   bit          m_err, m_we;
   logic [31:0] m_addr, m_wdata;

   function automatic int sval(input logic [12:0] imm);
      return int'($signed(imm));
   endfunction

   function automatic bit m_illegal(input int op, input logic [12:0] imm);
      int v;
      v = sval(imm);
      case (op)
         0, 1, 2, 3: return 1'b0;
         4, 5, 7:    return (v < -2048) || (v > 2047);
         6:          return (v % 2) != 0;
         8:          return (v < 0) || (v > 63);
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] m_encode(input int op, input int rd, input int rs1,
                                            input int rs2, input logic [12:0] imm);
      logic [31:0] u, r, s, d;
      u = 32'(sval(imm));
      r = 32'(rs2) << 20;
      s = 32'(rs1) << 15;
      d = 32'(rd) << 7;
      case (op)
         0: return r | s | d | 32'h33;
         1: return (32'd32 << 25) | r | s | d | 32'h33;
         2: return r | s | (32'd7 << 12) | d | 32'h33;
         3: return r | s | (32'd6 << 12) | d | 32'h33;
         4: return ((u & 32'hFFF) << 20) | s | (32'd3 << 12) | d | 32'h03;
         5: return (((u >> 5) & 32'h7F) << 25) | r | s | (32'd3 << 12) | ((u & 32'h1F) << 7) | 32'h23;
         6: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | r | s
                 | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
         7: return ((u & 32'hFFF) << 20) | s | d | 32'h13;
         8: return ((u & 32'h3F) << 20) | s | (32'd1 << 12) | d | 32'h13;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_ready();
      return (m_mode == 1) && (m_count < DEPTH - NOPS) && !m_err && !start && !finish;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_count = 0; m_flush_left = 0; m_err = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0;
      end else begin
         bit rdy;
         rdy  = m_ready();
         m_we = 1'b0;
         if (start) begin
            m_mode = 1; m_count = 0; m_err = 1'b0;
         end else if (m_mode == 1) begin
            if (finish) begin
               m_mode = 2; m_flush_left = NOPS;
            end else if (bus.req_valid && rdy) begin
               if (m_illegal(int'(bus.req_op), bus.req_imm)) begin
                  m_err = 1'b1;
               end else begin
                  m_we    = 1'b1;
                  m_addr  = 32'(m_count * 4);
                  m_wdata = m_encode(int'(bus.req_op), int'(bus.req_rd), int'(bus.req_rs1),
                                     int'(bus.req_rs2), bus.req_imm);
                  m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
               end
            end
         end else if (m_mode == 2) begin
            m_we    = 1'b1;
            m_addr  = 32'(m_count * 4);
            m_wdata = 32'h13;
            m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
            m_flush_left--;
            if (m_flush_left == 0) m_mode = 3;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_we", 32'(bus.imem_we), 0);
         chk("rst_ready", 32'(bus.req_ready), 0);
         chk("rst_addr", 32'(bus.imem_addr), 0);
         chk("rst_wdata", bus.imem_wdata, 0);
         chk("rst_count", 32'(count), 0);
         chk("rst_flags", {29'd0, busy, done, err}, 0);
      end else begin
         chk("req_ready", 32'(bus.req_ready), 32'(m_ready()));
         chk("imem_we", 32'(bus.imem_we), 32'(m_we));
         if (m_we) begin
            chk("imem_addr", 32'(bus.imem_addr), m_addr);
            chk("imem_wdata", bus.imem_wdata, m_wdata);
         end
         chk("count", 32'(count), 32'(m_count));
         chk("busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
         chk("done", 32'(done), 32'(m_mode == 3));
         chk("err", 32'(err), 32'(m_err));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int op, input int rd, input int rs1, input int rs2,
                          input logic [12:0] imm);
      bus.req_valid = 1'b1;
      bus.req_op    = 4'(op);
      bus.req_rd    = 5'(rd);
      bus.req_rs1   = 5'(rs1);
      bus.req_rs2   = 5'(rs2);
      bus.req_imm   = imm;
   endtask

   task automatic pulse_start();
      bus.req_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_finish();
      bus.req_valid = 1'b0;
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk(nm, 32'(done), 1);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_rd    = '0;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.req_imm   = '0;
      repeat (3) tick();
      chk("lit_rst_count", 32'(count), 0);
      chk("lit_rst_we", 32'(bus.imem_we), 0);
      rst_n = 1'b1;
      tick();

      // add / ld / sd / beq back-to-back, then an odd beq offset
      pulse_start();
      set_req(0, 3, 1, 2, 13'd0);
      tick();
      set_req(4, 5, 2, 0, 13'd8);
      chk("lit_add_we", 32'(bus.imem_we), 1);
      chk("lit_add_addr", 32'(bus.imem_addr), 32'h00);
      chk("lit_add_wdata", bus.imem_wdata, 32'h002081B3);
      tick();
      set_req(5, 0, 2, 5, 13'd16);
      chk("lit_ld_addr", 32'(bus.imem_addr), 32'h04);
      chk("lit_ld_wdata", bus.imem_wdata, 32'h00813283);
      tick();
      set_req(6, 0, 1, 2, 13'h1FF8);
      chk("lit_sd_we", 32'(bus.imem_we), 1);
      chk("lit_sd_addr", 32'(bus.imem_addr), 32'h08);
      chk("lit_sd_wdata", bus.imem_wdata, 32'h00513823);
      tick();
      set_req(6, 0, 1, 2, 13'd3);
      chk("lit_beq_addr", 32'(bus.imem_addr), 32'h0C);
      chk("lit_beq_wdata", bus.imem_wdata, 32'hFE208CE3);
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk("lit_beq_odd_err", 32'(err), 1);
      chk("lit_beq_odd_we", 32'(bus.imem_we), 0);
      chk("lit_beq_odd_ready", 32'(bus.req_ready), 0);
      chk("lit_beq_odd_count", 32'(count), 4);
      set_req(7, 1, 1, 0, 13'd1);
      tick();
      tick();
      pulse_finish();
      wait_done("session_a_done");
      chk("lit_a_count", 32'(count), 8);
      pulse_finish();
      tick();

      // two words then finish: NOPs at 0x08..0x14
      pulse_start();
      chk("lit_start_clr_err", 32'(err), 0);
      chk("lit_start_clr_count", 32'(count), 0);
      set_req(7, 6, 0, 0, 13'h1FFF);
      tick();
      set_req(8, 7, 6, 0, 13'd63);
      chk("lit_addi_wdata", bus.imem_wdata, 32'hFFF00313);
      tick();
      chk("lit_slli_wdata", bus.imem_wdata, 32'h03F31393);
      pulse_finish();
      tick();
      chk("lit_nop0_addr", 32'(bus.imem_addr), 32'h08);
      chk("lit_nop0_wdata", bus.imem_wdata, 32'h00000013);
      wait_done("session_b_done");
      chk("lit_b_last_addr", 32'(bus.imem_addr), 32'h14);
      chk("lit_b_count", 32'(count), 6);

      // remaining R-types, immediate boundaries, illegal ops
      pulse_start();
      set_req(1, 1, 2, 3, 13'd0);
      tick();
      set_req(2, 4, 5, 6, 13'd0);
      chk("lit_sub_wdata", bus.imem_wdata, 32'h403100B3);
      tick();
      set_req(3, 4, 5, 6, 13'd0);
      chk("lit_and_wdata", bus.imem_wdata, 32'h0062F233);
      tick();
      set_req(7, 1, 1, 0, 13'h07FF);
      chk("lit_or_wdata", bus.imem_wdata, 32'h0062E233);
      tick();
      set_req(5, 0, 2, 1, 13'h1800);
      chk("lit_addi_max_wdata", bus.imem_wdata, 32'h7FF08093);
      tick();
      set_req(7, 1, 1, 0, 13'h0800);
      tick();
      bus.req_valid = 1'b0;
      chk("lit_addi_2048_err", 32'(err), 1);
      pulse_finish();
      wait_done("session_c_done");
      pulse_start();
      set_req(9, 1, 1, 1, 13'd0);
      tick();
      bus.req_valid = 1'b0;
      chk("lit_op9_err", 32'(err), 1);
      pulse_start();
      set_req(8, 1, 1, 0, 13'd64);
      tick();
      bus.req_valid = 1'b0;
      chk("lit_slli64_err", 32'(err), 1);

      // fill to the reserved tail
      pulse_start();
      for (int i = 0; i < 60; i++) begin
         set_req(i % 9, i % 32, (i + 1) % 32, (i + 2) % 32,
                 13'(((i % 9) == 8) ? i : i * 4));
         tick();
      end
      set_req(0, 1, 1, 1, 13'd0);
      #1;
      chk("lit_full_count", 32'(count), 60);
      chk("lit_full_ready", 32'(bus.req_ready), 0);
      tick();
      tick();
      pulse_finish();
      wait_done("fill_done");
      chk("lit_fill_last_addr", 32'(bus.imem_addr), 32'hFC);
      chk("lit_fill_count", 32'(count), 64);
      tick();

      // start during FLUSH abandons the tail
      pulse_start();
      set_req(0, 1, 2, 3, 13'd0);
      tick();
      tick();
      pulse_finish();
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lit_restart_we", 32'(bus.imem_we), 0);
      chk("lit_restart_count", 32'(count), 0);
      chk("lit_restart_busy", 32'(busy), 1);
      tick();
      chk("lit_restart_no_nop", 32'(bus.imem_we), 0);
      tick();

      // async reset mid-LOAD
      set_req(3, 2, 2, 2, 13'd0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("lit_async_we", 32'(bus.imem_we), 0);
      chk("lit_async_wdata", bus.imem_wdata, 0);
      chk("lit_async_count", 32'(count), 0);
      chk("lit_async_busy", 32'(busy), 0);
      chk("lit_async_ready", 32'(bus.req_ready), 0);
      bus.req_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
